// File: rtl/conv_window_reader.sv
`default_nettype none
// ============================================================================
// Module      : conv_window_reader
// Description : Read side of the CNN pixel line buffer. Consumes a raster-order
//               pixel stream and emits every fully-populated 3x3 window (no
//               padding) for the convolution stage.
// Ports       :
//   clock      in   1          rising-edge clock
//   reset      in   1          synchronous, active-high
//   in_valid   in   1          data_in carries a pixel this cycle
//   data_in    in   DATA_W     pixel, raster order (row-major)
//   win_out    out  9*DATA_W   w[r][c] at bits [(3*r+c)*DATA_W +: DATA_W],
//                              r=0 oldest row, c=0 leftmost column
//   win_valid  out  1          one-cycle pulse: win_out holds a new window
//   frame_done out  1          one-cycle pulse: last pixel of frame accepted
// Revision    : 1.0 - initial release
// ============================================================================
module conv_window_reader #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_valid,
  input  logic [DATA_W-1:0]   data_in,
  output logic [9*DATA_W-1:0] win_out,
  output logic                win_valid,
  output logic                frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  localparam logic [CW-1:0] C_COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] C_ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] C_COL_TWO  = CW'(2);
  localparam logic [RW-1:0] C_ROW_TWO  = RW'(2);

  logic [CW-1:0]     r_col;
  logic [RW-1:0]     r_row;
  logic              r_win_valid;
  logic              r_frame_done;
  logic [DATA_W-1:0] r_win [0:2][0:2];

  // r_lb1 holds the previous row, r_lb0 the row before that, both by column.
  logic [DATA_W-1:0] r_lb0 [0:IMG_W-1];
  logic [DATA_W-1:0] r_lb1 [0:IMG_W-1];

  logic w_col_last;
  logic w_row_last;

  assign w_col_last = (r_col == C_COL_LAST);
  assign w_row_last = (r_row == C_ROW_LAST);

  // Counters, window shift register and output strobes.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_col        <= '0;
      r_row        <= '0;
      r_win_valid  <= 1'b0;
      r_frame_done <= 1'b0;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          r_win[r][c] <= '0;
        end
      end
    end else begin
      // Columns 0/1 of each row still carry stale columns from the previous
      // row, so only positions with col>=2 and row>=2 produce a window.
      r_win_valid  <= in_valid && (r_row >= C_ROW_TWO) && (r_col >= C_COL_TWO);
      r_frame_done <= in_valid && w_row_last && w_col_last;
      if (in_valid) begin
        for (int r = 0; r < 3; r++) begin
          r_win[r][0] <= r_win[r][1];
          r_win[r][1] <= r_win[r][2];
        end
        r_win[0][2] <= r_lb0[r_col];
        r_win[1][2] <= r_lb1[r_col];
        r_win[2][2] <= data_in;

        if (w_col_last) begin
          r_col <= '0;
          r_row <= w_row_last ? '0 : r_row + RW'(1);
        end else begin
          r_col <= r_col + CW'(1);
        end
      end
    end
  end

  // Row buffers carry no reset: their content is only ever emitted once the
  // row counter proves it was written during the current frame.
  always_ff @(posedge clock) begin
    if (!reset && in_valid) begin
      r_lb0[r_col] <= r_lb1[r_col];
      r_lb1[r_col] <= data_in;
    end
  end

  for (genvar gr = 0; gr < 3; gr++) begin : g_row
    for (genvar gc = 0; gc < 3; gc++) begin : g_col
      assign win_out[(3*gr+gc)*DATA_W +: DATA_W] = r_win[gr][gc];
    end
  end

  assign win_valid  = r_win_valid;
  assign frame_done = r_frame_done;

endmodule
`default_nettype wire
